// File: rtl/nipcb_stim_scheduler.sv
// Steps through the programmed stimulation table, loading each enabled entry onto
// the NI PCB stimulation core, triggering it and pacing pulses with a gap counter.
module nipcb_stim_scheduler #(
    parameter  int DATA_WIDTH    = 32,
    parameter  int NUM_ENTRIES   = 4,
    parameter  int START_TIMEOUT = 1024,
    localparam int ENTRY_AW      = $clog2(NUM_ENTRIES)
) (
    input  logic                  CLK,
    input  logic                  RESETn,
    input  logic                  start,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] rounds,
    input  logic [DATA_WIDTH-1:0] gap_cycles,
    input  logic                  tbl_we,
    input  logic [ENTRY_AW-1:0]   tbl_addr,
    input  logic                  tbl_en,
    input  logic [1:0]            tbl_chan,
    input  logic [DATA_WIDTH-1:0] tbl_high,
    input  logic [DATA_WIDTH-1:0] tbl_low,
    input  logic [DATA_WIDTH-1:0] tbl_count,
    input  logic [DATA_WIDTH-1:0] tbl_mag_high,
    input  logic [DATA_WIDTH-1:0] tbl_mag_low,
    output logic [1:0]            core_channel_select,
    output logic [DATA_WIDTH-1:0] core_cycles_high,
    output logic [DATA_WIDTH-1:0] core_cycles_low,
    output logic [DATA_WIDTH-1:0] core_cycles_count,
    output logic [DATA_WIDTH-1:0] core_magnitude_high,
    output logic [DATA_WIDTH-1:0] core_magnitude_low,
    output logic                  core_trigger,
    input  logic                  core_running,
    output logic                  busy,
    output logic                  done,
    output logic [ENTRY_AW-1:0]   cur_entry,
    output logic [DATA_WIDTH-1:0] rounds_done,
    output logic                  err_timeout,
    output logic                  err_empty,
    output logic                  tbl_wr_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_SCAN, S_LOAD, S_TRIG, S_WAIT_START, S_WAIT_END, S_GAP, S_DONE
    } state_t;

    // One extra index bit: the value NUM_ENTRIES marks "past the last entry".
    localparam logic [ENTRY_AW:0]     IDX_WRAP = (ENTRY_AW+1)'(NUM_ENTRIES);
    localparam logic [DATA_WIDTH-1:0] TO_LIM   = DATA_WIDTH'(START_TIMEOUT);
    localparam logic [DATA_WIDTH-1:0] ONE      = DATA_WIDTH'(1);

    function automatic logic [DATA_WIDTH-1:0] rd_inc(input logic [DATA_WIDTH-1:0] val,
                                                     input logic sat);
        if (sat && (&val))
            return val;
        return val + ONE;
    endfunction

    state_t                r_state, w_next;
    logic [ENTRY_AW:0]     r_idx, w_idx;
    logic [DATA_WIDTH-1:0] r_cnt, w_cnt;
    logic [DATA_WIDTH-1:0] r_rounds_done, w_rd;
    logic                  r_seen, w_seen;
    logic                  w_accept, w_set_empty, w_set_to, w_tbl_wr;
    logic [ENTRY_AW-1:0]   w_ent;

    logic [DATA_WIDTH-1:0] r_rounds, r_gap;
    logic                  r_busy, r_done, r_trig, r_err_to, r_err_empty, r_wr_err;
    logic [ENTRY_AW-1:0]   r_cur_entry;
    logic [1:0]            r_core_chan;
    logic [DATA_WIDTH-1:0] r_core_high, r_core_low, r_core_count, r_core_mh, r_core_ml;

    logic                  r_tbl_en   [NUM_ENTRIES];
    logic [1:0]            r_tbl_chan [NUM_ENTRIES];
    logic [DATA_WIDTH-1:0] r_tbl_high [NUM_ENTRIES];
    logic [DATA_WIDTH-1:0] r_tbl_low  [NUM_ENTRIES];
    logic [DATA_WIDTH-1:0] r_tbl_cnt  [NUM_ENTRIES];
    logic [DATA_WIDTH-1:0] r_tbl_mh   [NUM_ENTRIES];
    logic [DATA_WIDTH-1:0] r_tbl_ml   [NUM_ENTRIES];

    assign w_ent    = r_idx[ENTRY_AW-1:0];
    assign w_tbl_wr = tbl_we && (r_state == S_IDLE);

    always_comb begin
        w_next      = r_state;
        w_idx       = r_idx;
        w_cnt       = r_cnt;
        w_rd        = r_rounds_done;
        w_seen      = r_seen;
        w_accept    = 1'b0;
        w_set_empty = 1'b0;
        w_set_to    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_idx    = '0;
                    w_rd     = '0;
                    w_seen   = 1'b0;
                    w_next   = S_SCAN;
                end
            end
            S_SCAN: begin
                if (r_idx == IDX_WRAP) begin
                    if (!r_seen) begin
                        w_set_empty = 1'b1;
                        w_next      = S_DONE;
                    end else begin
                        w_rd  = rd_inc(r_rounds_done, r_rounds == '0);
                        w_idx = '0;
                        if ((r_rounds != '0) && ((r_rounds_done + ONE) == r_rounds))
                            w_next = S_DONE;
                    end
                end else if (r_tbl_en[w_ent]) begin
                    w_seen = 1'b1;
                    w_next = S_LOAD;
                end else begin
                    w_idx = r_idx + 1'b1;
                end
            end
            S_LOAD: w_next = S_TRIG;
            S_TRIG: begin
                w_cnt  = '0;
                w_next = S_WAIT_START;
            end
            S_WAIT_START: begin
                if (core_running) begin
                    w_next = S_WAIT_END;
                end else begin
                    w_cnt = r_cnt + ONE;
                    if ((r_cnt + ONE) == TO_LIM) begin
                        w_set_to = 1'b1;
                        w_next   = S_IDLE;
                    end
                end
            end
            S_WAIT_END: begin
                if (!core_running) begin
                    if (r_gap != '0) begin
                        w_cnt  = '0;
                        w_next = S_GAP;
                    end else begin
                        w_idx  = r_idx + 1'b1;
                        w_next = S_SCAN;
                    end
                end
            end
            S_GAP: begin
                if ((r_cnt + ONE) == r_gap) begin
                    w_idx  = r_idx + 1'b1;
                    w_next = S_SCAN;
                end else begin
                    w_cnt = r_cnt + ONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        // Abort freezes all bookkeeping and returns to IDLE from anywhere.
        if (abort) begin
            w_next      = S_IDLE;
            w_idx       = r_idx;
            w_cnt       = r_cnt;
            w_rd        = r_rounds_done;
            w_seen      = r_seen;
            w_accept    = 1'b0;
            w_set_empty = 1'b0;
            w_set_to    = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_cnt         <= '0;
            r_rounds_done <= '0;
            r_seen        <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_trig        <= 1'b0;
            r_err_to      <= 1'b0;
            r_err_empty   <= 1'b0;
            r_wr_err      <= 1'b0;
            r_cur_entry   <= '0;
            r_core_chan   <= '0;
            r_core_high   <= '0;
            r_core_low    <= '0;
            r_core_count  <= '0;
            r_core_mh     <= '0;
            r_core_ml     <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++)
                r_tbl_en[i] <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_idx         <= w_idx;
            r_cnt         <= w_cnt;
            r_rounds_done <= w_rd;
            r_seen        <= w_seen;
            r_busy        <= (w_next != S_IDLE);
            r_done        <= (w_next == S_DONE);
            r_trig        <= (w_next == S_TRIG);
            r_wr_err      <= tbl_we && (r_state != S_IDLE);
            if (w_accept) begin
                r_err_to    <= 1'b0;
                r_err_empty <= 1'b0;
            end
            if (w_set_to)
                r_err_to <= 1'b1;
            if (w_set_empty)
                r_err_empty <= 1'b1;
            if ((r_state == S_LOAD) && !abort) begin
                r_cur_entry  <= w_ent;
                r_core_chan  <= r_tbl_chan[w_ent];
                r_core_high  <= r_tbl_high[w_ent];
                r_core_low   <= r_tbl_low[w_ent];
                r_core_count <= r_tbl_cnt[w_ent];
                r_core_mh    <= r_tbl_mh[w_ent];
                r_core_ml    <= r_tbl_ml[w_ent];
            end
            if (w_tbl_wr)
                r_tbl_en[tbl_addr] <= tbl_en;
        end
    end

    // Table payload and run parameters carry no reset; only the enables matter.
    always_ff @(posedge CLK) begin
        if (w_tbl_wr) begin
            r_tbl_chan[tbl_addr] <= tbl_chan;
            r_tbl_high[tbl_addr] <= tbl_high;
            r_tbl_low[tbl_addr]  <= tbl_low;
            r_tbl_cnt[tbl_addr]  <= tbl_count;
            r_tbl_mh[tbl_addr]   <= tbl_mag_high;
            r_tbl_ml[tbl_addr]   <= tbl_mag_low;
        end
        if (w_accept) begin
            r_rounds <= rounds;
            r_gap    <= gap_cycles;
        end
    end

    assign core_channel_select = r_core_chan;
    assign core_cycles_high    = r_core_high;
    assign core_cycles_low     = r_core_low;
    assign core_cycles_count   = r_core_count;
    assign core_magnitude_high = r_core_mh;
    assign core_magnitude_low  = r_core_ml;
    assign core_trigger        = r_trig;
    assign busy                = r_busy;
    assign done                = r_done;
    assign cur_entry           = r_cur_entry;
    assign rounds_done         = r_rounds_done;
    assign err_timeout         = r_err_to;
    assign err_empty           = r_err_empty;
    assign tbl_wr_err          = r_wr_err;

endmodule

// File: tb/tb_nipcb_stim_scheduler.sv
// Randomized bench for nipcb_stim_scheduler: a table model plus a simple core model
// predict trigger order, payloads, timing, round counts and error flags.
module tb_nipcb_stim_scheduler;
    localparam int DW = 32;
    localparam int NE = 4;
    localparam int AW = 2;
    localparam int TO = 40;

    logic          CLK = 1'b0;
    logic          RESETn;
    logic          start, abort;
    logic [DW-1:0] rounds, gap_cycles;
    logic          tbl_we;
    logic [AW-1:0] tbl_addr;
    logic          tbl_en;
    logic [1:0]    tbl_chan;
    logic [DW-1:0] tbl_high, tbl_low, tbl_count, tbl_mag_high, tbl_mag_low;
    logic [1:0]    core_channel_select;
    logic [DW-1:0] core_cycles_high, core_cycles_low, core_cycles_count;
    logic [DW-1:0] core_magnitude_high, core_magnitude_low;
    logic          core_trigger, core_running, busy, done;
    logic [AW-1:0] cur_entry;
    logic [DW-1:0] rounds_done;
    logic          err_timeout, err_empty, tbl_wr_err;

    nipcb_stim_scheduler #(.DATA_WIDTH(DW), .NUM_ENTRIES(NE), .START_TIMEOUT(TO)) dut (
        .CLK(CLK), .RESETn(RESETn), .start(start), .abort(abort),
        .rounds(rounds), .gap_cycles(gap_cycles),
        .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_en(tbl_en), .tbl_chan(tbl_chan),
        .tbl_high(tbl_high), .tbl_low(tbl_low), .tbl_count(tbl_count),
        .tbl_mag_high(tbl_mag_high), .tbl_mag_low(tbl_mag_low),
        .core_channel_select(core_channel_select),
        .core_cycles_high(core_cycles_high), .core_cycles_low(core_cycles_low),
        .core_cycles_count(core_cycles_count),
        .core_magnitude_high(core_magnitude_high), .core_magnitude_low(core_magnitude_low),
        .core_trigger(core_trigger), .core_running(core_running),
        .busy(busy), .done(done), .cur_entry(cur_entry), .rounds_done(rounds_done),
        .err_timeout(err_timeout), .err_empty(err_empty), .tbl_wr_err(tbl_wr_err)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference table contents as the bench believes them to be.
    bit            m_en   [NE];
    logic [1:0]    m_chan [NE];
    logic [DW-1:0] m_high [NE], m_low [NE], m_cnt [NE], m_mh [NE], m_ml [NE];

    // Core model: after a trigger it holds running high for core_len cycles.
    bit core_on  = 1'b1;
    int core_len = 4;
    int core_rem = 0;
    int fall_cyc = 0;
    initial begin
        core_running = 1'b0;
        forever begin
            @(negedge CLK);
            if (!RESETn) begin
                core_running = 1'b0;
                core_rem     = 0;
            end else if (core_on && core_trigger) begin
                core_running = 1'b1;
                core_rem     = core_len;
            end else if (core_rem > 0) begin
                core_rem--;
                if (core_rem == 0) begin
                    core_running = 1'b0;
                    fall_cyc     = cyc;
                end
            end
        end
    end

    task automatic write_entry(input int i, input bit en, input logic [1:0] ch,
                               input logic [DW-1:0] h, l, c, mh, ml);
        @(negedge CLK);
        tbl_we = 1'b1; tbl_addr = AW'(i); tbl_en = en; tbl_chan = ch;
        tbl_high = h; tbl_low = l; tbl_count = c; tbl_mag_high = mh; tbl_mag_low = ml;
        @(negedge CLK);
        tbl_we = 1'b0;
        m_en[i] = en; m_chan[i] = ch; m_high[i] = h; m_low[i] = l;
        m_cnt[i] = c; m_mh[i] = mh; m_ml[i] = ml;
    endtask

    task automatic rand_entry(input int i, input bit en);
        write_entry(i, en, 2'($urandom_range(0, 3)), $urandom(), $urandom(), $urandom(),
                    $urandom(), $urandom());
    endtask

    task automatic pulse_start(input int r, input int g, output int sc);
        @(negedge CLK);
        rounds = DW'(r); gap_cycles = DW'(g); start = 1'b1;
        sc = cyc;
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic check_zero_outputs();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_trigger", core_trigger, 0);
        chk("rst_err_timeout", err_timeout, 0);
        chk("rst_err_empty", err_empty, 0);
        chk("rst_wr_err", tbl_wr_err, 0);
        chk("rst_cur_entry", cur_entry, 0);
        chk("rst_rounds_done", rounds_done, 0);
        chk("rst_chan", core_channel_select, 0);
        chk("rst_high", core_cycles_high, 0);
        chk("rst_low", core_cycles_low, 0);
        chk("rst_count", core_cycles_count, 0);
        chk("rst_mag_high", core_magnitude_high, 0);
        chk("rst_mag_low", core_magnitude_low, 0);
    endtask

    // Full run: every trigger is matched against the expected entry sequence.
    task automatic run_program(input int r, input int g, input bit inject);
        int q[$];
        int sc, prev, j, inj;
        bit fin;
        for (int rr = 0; rr < r; rr++)
            for (int i = 0; i < NE; i++)
                if (m_en[i]) q.push_back(i);
        pulse_start(r, g, sc);
        chk("start_busy", busy, 1);
        chk("start_clr_err_timeout", err_timeout, 0);
        chk("start_clr_err_empty", err_empty, 0);
        prev = -1; inj = 0; fin = 1'b0;
        for (int k = 0; k < 3000 && !fin; k++) begin
            if (k > 0) @(negedge CLK);
            if (inj == 2) begin
                chk("wr_err_one_cycle", tbl_wr_err, 0);
                inj = 3;
            end
            if (inj == 1) begin
                tbl_we = 1'b0;
                chk("wr_err_pulse", tbl_wr_err, 1);
                inj = 2;
            end
            if (core_trigger) begin
                if (q.size() == 0) begin
                    chk("extra_trigger", 1, 0);
                end else begin
                    j = q.pop_front();
                    chk("trig_chan", core_channel_select, m_chan[j]);
                    chk("trig_high", core_cycles_high, m_high[j]);
                    chk("trig_low", core_cycles_low, m_low[j]);
                    chk("trig_count", core_cycles_count, m_cnt[j]);
                    chk("trig_mag_high", core_magnitude_high, m_mh[j]);
                    chk("trig_mag_low", core_magnitude_low, m_ml[j]);
                    chk("trig_cur_entry", cur_entry, j);
                    if (prev < 0)
                        chk("start_to_trigger", cyc - sc, 3 + j);
                    else if (j > prev)
                        chk("end_to_next_trigger", cyc - fall_cyc, 2 + g + j - prev);
                    prev = j;
                    if (inject && inj == 0) begin
                        tbl_we = 1'b1; tbl_addr = AW'(j); tbl_en = 1'b0;
                        tbl_chan = ~m_chan[j]; tbl_high = ~m_high[j];
                        tbl_low = ~m_low[j]; tbl_count = ~m_cnt[j];
                        tbl_mag_high = ~m_mh[j]; tbl_mag_low = ~m_ml[j];
                        inj = 1;
                    end
                end
            end
            if (done) fin = 1'b1;
        end
        tbl_we = 1'b0;
        chk("done_seen", fin, 1);
        chk("triggers_missing", q.size(), 0);
        chk("rounds_done", rounds_done, DW'(r));
        chk("run_err_empty", err_empty, 0);
        chk("run_err_timeout", err_timeout, 0);
        @(negedge CLK);
        chk("busy_after_done", busy, 0);
        chk("done_single_pulse", done, 0);
    endtask

    task automatic empty_run();
        int sc, ntrig, dcyc;
        bit fin;
        pulse_start(1, 0, sc);
        ntrig = 0; fin = 1'b0; dcyc = 0;
        for (int k = 0; k < 20 && !fin; k++) begin
            if (k > 0) @(negedge CLK);
            if (core_trigger) ntrig++;
            if (done) begin fin = 1'b1; dcyc = cyc; end
        end
        chk("empty_done_seen", fin, 1);
        chk("empty_done_in_time", (dcyc - sc) <= NE + 2, 1);
        chk("empty_err_empty", err_empty, 1);
        chk("empty_no_trigger", ntrig, 0);
        @(negedge CLK);
        chk("empty_busy_after", busy, 0);
    endtask

    task automatic wait_trig(input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget && !ok; k++) begin
            @(negedge CLK);
            if (core_trigger) ok = 1'b1;
        end
        chk("trigger_arrived", ok, 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sc, nt, nd, a, b;
        bit ok, any;
        RESETn = 1'b0; start = 1'b0; abort = 1'b0; rounds = '0; gap_cycles = '0;
        tbl_we = 1'b0; tbl_addr = '0; tbl_en = 1'b0; tbl_chan = '0;
        tbl_high = '0; tbl_low = '0; tbl_count = '0; tbl_mag_high = '0; tbl_mag_low = '0;
        for (int i = 0; i < NE; i++) m_en[i] = 1'b0;
        repeat (3) @(negedge CLK);
        check_zero_outputs();
        RESETn = 1'b1;

        // start and abort together in IDLE: abort wins
        @(negedge CLK);
        start = 1'b1; abort = 1'b1;
        @(negedge CLK);
        start = 1'b0; abort = 1'b0;
        chk("start_abort_idle", busy, 0);

        // table cleared by reset -> empty error
        empty_run();

        // entries 0 (chan 1) and 2 (chan 3), two rounds, gap 5
        write_entry(0, 1'b1, 2'd1, 32'd10, 32'd20, 32'd3, 32'd100, 32'd50);
        write_entry(2, 1'b1, 2'd3, 32'd11, 32'd21, 32'd4, 32'd200, 32'd60);
        core_len = 20;
        run_program(2, 5, 1'b0);

        // single entry 0: latency and payload
        rand_entry(0, 1'b1);
        write_entry(2, 1'b0, 2'd0, '0, '0, '0, '0, '0);
        core_len = 3;
        run_program(1, 0, 1'b0);

        // randomized tables; one run writes the table while busy
        for (int it = 0; it < 5; it++) begin
            any = 1'b0;
            for (int i = 0; i < NE; i++) begin
                rand_entry(i, 1'($urandom_range(0, 1)));
                any = any | m_en[i];
            end
            if (!any) rand_entry($urandom_range(0, NE - 1), 1'b1);
            core_len = $urandom_range(2, 8);
            run_program($urandom_range(1, 3), $urandom_range(0, 6), it == 2);
            if (it == 2) run_program(1, $urandom_range(0, 6), 1'b0);
        end

        // core never starts -> timeout
        core_on = 1'b0;
        pulse_start(1, 0, sc);
        wait_trig(NE + 4, ok);
        nd = 0;
        for (int k = 1; k <= TO + 1; k++) begin
            @(negedge CLK);
            if (done) nd++;
            if (k == TO - 1) chk("timeout_not_early", err_timeout, 0);
            if (k == TO + 1) begin
                chk("timeout_err", err_timeout, 1);
                chk("timeout_busy", busy, 0);
            end
        end
        repeat (3) begin
            @(negedge CLK);
            if (done) nd++;
        end
        chk("timeout_no_done", nd, 0);
        core_on = 1'b1;
        core_len = 4;
        run_program(1, 1, 1'b0);

        // rounds=0, abort in WAIT_END of the third pulse
        a = $urandom_range(0, NE - 2);
        b = $urandom_range(a + 1, NE - 1);
        for (int i = 0; i < NE; i++) rand_entry(i, (i == a) || (i == b));
        core_len = 6;
        pulse_start(0, 2, sc);
        nt = 0; nd = 0;
        for (int k = 0; k < 500 && nt < 3; k++) begin
            @(negedge CLK);
            if (done) nd++;
            if (core_trigger) nt++;
        end
        chk("abort_third_trigger", nt, 3);
        repeat (3) begin
            @(negedge CLK);
            if (done) nd++;
        end
        abort = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
        chk("abort_busy_low", busy, 0);
        chk("abort_rounds_done", rounds_done, 1);
        chk("abort_core_hold", core_channel_select, m_chan[a]);
        nt = 0;
        repeat (40) begin
            @(negedge CLK);
            if (done) nd++;
            if (core_trigger) nt++;
        end
        chk("abort_no_more_triggers", nt, 0);
        chk("abort_no_done", nd, 0);

        // reset in the middle of a long gap
        for (int i = 0; i < NE; i++) rand_entry(i, i == 0);
        core_len = 3;
        pulse_start(1, 20, sc);
        wait_trig(NE + 4, ok);
        repeat (core_len + 6) @(negedge CLK);
        RESETn = 1'b0;
        @(negedge CLK);
        check_zero_outputs();
        @(negedge CLK);
        RESETn = 1'b1;
        for (int i = 0; i < NE; i++) m_en[i] = 1'b0;
        empty_run();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
